// File: rtl/axi_write_dispatcher.sv
// -----------------------------------------------------------------------------
// axi_write_dispatcher
//
// Takes a write job (64-byte aligned base address plus a beat count). It buffers
// the job's 512-bit input stream in a show-ahead FIFO. It splits the job into
// write-master burst requests that never cross a 4 KB boundary. A burst holds at
// most MAX_BURST_BEATS beats. The next burst is issued only after the previous
// burst's write response has arrived.
//
// Optional feature (macro AXI_WRITE_DISPATCHER_FULL_BURST_EN):
//   defined   -> a request is raised only once the whole burst is buffered
//   undefined -> a request is raised as soon as one beat is buffered
//
// Ports:
//   core_clk, resetn        clock (rising edge), async active-low reset
//   job_valid/job_ready     job handshake; job_base_address[33:0],
//                           job_num_beats[15:0]
//   in_valid/in_ready       input beat stream, in_data[511:0]
//   wm_req_valid/ready      burst request: wm_req_start_address[33:0],
//                           wm_req_len[7:0] (beats-1)
//   data_queue_pop          write master consumes the FIFO head
//   data_queue_data_valid   FIFO non-empty; data_queue_data[511:0] is the head
//   wm_resp_valid/ready     burst write response (ready tied high)
//   job_done                one-cycle pulse when the job completes
//   busy                    job in progress
// -----------------------------------------------------------------------------
module axi_write_dispatcher #(
  parameter int FIFO_DEPTH      = 16,
  parameter int MAX_BURST_BEATS = 64
) (
  input  logic         core_clk,
  input  logic         resetn,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [33:0]  job_base_address,
  input  logic [15:0]  job_num_beats,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_data,
  output logic         wm_req_valid,
  input  logic         wm_req_ready,
  output logic [33:0]  wm_req_start_address,
  output logic [7:0]   wm_req_len,
  input  logic         data_queue_pop,
  output logic         data_queue_data_valid,
  output logic [511:0] data_queue_data,
  input  logic         wm_resp_valid,
  output logic         wm_resp_ready,
  output logic         job_done,
  output logic         busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [33:0] ADDR_MASK = 34'h3_FFFF_FFC0;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CALC = 3'd1,
    REQ  = 3'd2,
    RESP = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t         state_r;
  logic [33:0]    addr_r;
  logic [15:0]    remaining_r;
  logic [15:0]    to_accept_r;
  logic [15:0]    burst_r;
  logic [7:0]     len_r;
  logic           req_valid_r;
  logic           job_ready_r;
  logic           busy_r;
  logic           job_done_r;

  logic [511:0]   mem_r [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr_r;
  logic [PW-1:0]  rd_ptr_r;
  logic [CW-1:0]  count_r;

  logic           job_accept_s;
  logic           full_s;
  logic           push_s;
  logic           pop_s;
  logic           data_ok_s;
  logic [15:0]    room_s;
  logic [15:0]    cap_s;
  logic [15:0]    burst_s;

  assign job_accept_s = (state_r == IDLE) && job_valid && job_ready_r;
  assign full_s       = (count_r == CW'(FIFO_DEPTH));
  assign in_ready     = busy_r && !full_s && (to_accept_r != 16'd0);
  assign push_s       = in_valid && in_ready;
  // A pop on an empty FIFO is dropped here, so pointers and count never move.
  assign pop_s        = data_queue_pop && (count_r != {CW{1'b0}});

  // Beats left before the next 4 KB boundary (1..64), then the three-way min.
  assign room_s  = 16'd64 - {10'd0, addr_r[11:6]};
  assign cap_s   = (remaining_r > 16'(MAX_BURST_BEATS)) ? 16'(MAX_BURST_BEATS) : remaining_r;
  assign burst_s = (cap_s > room_s) ? room_s : cap_s;

`ifdef AXI_WRITE_DISPATCHER_FULL_BURST_EN
  assign data_ok_s = (32'(count_r) >= 32'(burst_r));
`else
  assign data_ok_s = (count_r != {CW{1'b0}});
`endif

  assign job_ready             = job_ready_r;
  assign busy                  = busy_r;
  assign job_done              = job_done_r;
  assign wm_req_valid          = req_valid_r;
  assign wm_req_start_address  = addr_r;
  assign wm_req_len            = len_r;
  assign wm_resp_ready         = 1'b1;
  assign data_queue_data_valid = (count_r != {CW{1'b0}});
  // Forced to zero when empty so stale or uninitialised storage never shows.
  assign data_queue_data       = data_queue_data_valid ? mem_r[rd_ptr_r] : {512{1'b0}};

  // Burst-splitting FSM with registered handshake and status outputs.
  always_ff @(posedge core_clk or negedge resetn) begin
    if (!resetn) begin
      state_r     <= IDLE;
      addr_r      <= 34'd0;
      remaining_r <= 16'd0;
      burst_r     <= 16'd0;
      len_r       <= 8'd0;
      req_valid_r <= 1'b0;
      job_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      job_done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (job_accept_s) begin
            addr_r      <= job_base_address & ADDR_MASK;
            remaining_r <= job_num_beats;
            job_ready_r <= 1'b0;
            if (job_num_beats == 16'd0) begin
              state_r    <= DONE;
              job_done_r <= 1'b1;
              busy_r     <= 1'b0;
            end else begin
              state_r <= CALC;
              busy_r  <= 1'b1;
            end
          end
        end
        CALC: begin
          burst_r <= burst_s;
          len_r   <= 8'(burst_s - 16'd1);
          state_r <= REQ;
        end
        REQ: begin
          // Once raised, the request stays up unchanged until it is taken.
          if (req_valid_r) begin
            if (wm_req_ready) begin
              req_valid_r <= 1'b0;
              addr_r      <= addr_r + {12'd0, burst_r, 6'd0};
              remaining_r <= remaining_r - burst_r;
              state_r     <= RESP;
            end
          end else if (data_ok_s) begin
            req_valid_r <= 1'b1;
          end
        end
        RESP: begin
          if (wm_resp_valid) begin
            if (remaining_r != 16'd0) begin
              state_r <= CALC;
            end else begin
              state_r    <= DONE;
              job_done_r <= 1'b1;
              busy_r     <= 1'b0;
            end
          end
        end
        DONE: begin
          job_done_r  <= 1'b0;
          job_ready_r <= 1'b1;
          state_r     <= IDLE;
        end
        default: begin
          state_r     <= IDLE;
          req_valid_r <= 1'b0;
          job_ready_r <= 1'b1;
          busy_r      <= 1'b0;
          job_done_r  <= 1'b0;
        end
      endcase
    end
  end

  // Count of input beats the current job may still accept.
  always_ff @(posedge core_clk or negedge resetn) begin
    if (!resetn) begin
      to_accept_r <= 16'd0;
    end else if (job_accept_s) begin
      to_accept_r <= job_num_beats;
    end else if (push_s) begin
      to_accept_r <= to_accept_r - 16'd1;
    end else begin
      to_accept_r <= to_accept_r;
    end
  end

  // FIFO pointers and occupancy; push and pop are independent of the FSM.
  always_ff @(posedge core_clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage; contents need no reset because the empty state masks them.
  always_ff @(posedge core_clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_data;
    end
  end

endmodule
